stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 22 ++
 rtl/stream_mux_rr.sv | 107 ++++++++++
 tb/tb_stream_mux_rr.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and the round-robin pick helper for the stream mux family.
package stream_mux_pkg;

   typedef enum logic [0:0] {IDLE, LOCKED} state_t;

   localparam int unsigned MAX_CH   = 16;
   localparam int unsigned MAX_SELW = 4;

   typedef struct packed {
      logic                found;
      logic [MAX_SELW-1:0] idx;
   } pick_t;

   // First requester at or after ptr+1 (mod n), searching upward with wrap.
   function automatic pick_t rr_pick(input logic [MAX_CH-1:0]   req,
                                     input logic [MAX_SELW-1:0] ptr,
                                     input int unsigned         n);
      pick_t       p;
      int unsigned c;
      p = '0;
      for (int unsigned k = 1; k <= MAX_CH; k++) begin
         if (k <= n && !p.found) begin
            c = (32'(ptr) + k) % n;
            if (req[c]) begin
               p.found = 1'b1;
               p.idx   = MAX_SELW'(c);
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter over CHANNELS requests.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SELW     = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SELW-1:0]     ptr,
   output logic [SELW-1:0]     grant,
   output logic                found
);

   pick_t pick;

   always_comb begin
      pick  = rr_pick(MAX_CH'(req), MAX_SELW'(ptr), CHANNELS);
      grant = SELW'(pick.idx);
      found = pick.found;
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux; grants are held for a whole packet.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS-1:0]       in_last,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   output logic                      out_last,
   output logic [SELW-1:0]           out_chan,
   input  logic                      out_ready
);

   localparam int unsigned PADW = 1 << SELW;

   state_t              state;
   logic [SELW-1:0]     grant;
   logic [SELW-1:0]     ptr;
   logic [CHANNELS-1:0] req;
   logic [SELW-1:0]     arb_grant;
   logic                arb_found;
   logic                sel_ok;
   logic [PADW-1:0]     valid_pad;
   logic [PADW-1:0]     last_pad;
   logic [WIDTH-1:0]    g_data;
   logic                g_valid;
   logic                g_last;
   logic                g_ready;
   logic                xfer;

   // In fixed mode the only candidate is sel, so the arbiter picks it regardless of ptr.
   always_comb begin
      sel_ok = 32'(sel) < CHANNELS;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         req[i] = mode ? (sel_ok && (sel == SELW'(i)) && in_valid[i]) : in_valid[i];
      end
   end

   rr_arbiter #(
      .CHANNELS (CHANNELS),
      .SELW     (SELW)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (arb_grant),
      .found (arb_found)
   );

   always_comb begin
      valid_pad = PADW'(in_valid);
      last_pad  = PADW'(in_last);
      g_valid   = valid_pad[grant];
      g_last    = last_pad[grant];
      g_data    = in_data[32'(grant)*WIDTH +: WIDTH];
      g_ready   = (state == LOCKED) && (!out_valid || out_ready);
      in_ready  = g_ready ? (CHANNELS'(1) << grant) : '0;
      xfer      = g_ready && g_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         ptr       <= SELW'(CHANNELS - 1);
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_chan  <= '0;
      end else begin
         if (xfer) begin
            out_data  <= g_data;
            out_last  <= g_last;
            out_chan  <= grant;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (arb_found) begin
                  grant <= arb_grant;
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               if (xfer && g_last) begin
                  ptr   <= grant;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized bench for stream_mux_rr against a cycle-level behavioural model.
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic [3:0]  in_valid, in_last, in_ready;
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  out_data;
   logic        out_valid, out_last, out_ready;
   logic [1:0]  out_chan;

   // Five-channel instance so an out-of-range select is expressible.
   logic [19:0] d5_in_data;
   logic [4:0]  d5_in_valid, d5_in_last, d5_in_ready;
   logic        d5_mode;
   logic [2:0]  d5_sel;
   logic [3:0]  d5_out_data;
   logic        d5_out_valid, d5_out_last, d5_out_ready;
   logic [2:0]  d5_out_chan;

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(4), .CHANNELS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_chan  (out_chan),
      .out_ready (out_ready)
   );

   stream_mux_rr #(.WIDTH(4), .CHANNELS(5)) dut5 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (d5_in_data),
      .in_valid  (d5_in_valid),
      .in_last   (d5_in_last),
      .in_ready  (d5_in_ready),
      .mode      (d5_mode),
      .sel       (d5_sel),
      .out_data  (d5_out_data),
      .out_valid (d5_out_valid),
      .out_last  (d5_out_last),
      .out_chan  (d5_out_chan),
      .out_ready (d5_out_ready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: one packet owner at a time, output register with handshake.
   bit         m_locked;
   int         m_g, m_ptr, m_oc;
   bit         m_ov, m_ol;
   logic [3:0] m_od;

   // Producers: beats left in current packet, and the pending (offered) beat.
   int         rem[4];
   bit         pval[4];
   logic [3:0] pdata[4];

   int vprob, orp, pol, fixsel, rstp;

   task automatic model_reset();
      m_locked = 0; m_g = 0; m_ptr = 3;
      m_ov = 0; m_ol = 0; m_od = '0; m_oc = 0;
      for (int c = 0; c < 4; c++) begin
         rem[c] = 0; pval[c] = 0; pdata[c] = '0;
      end
   endtask

   task automatic model_step(output int acc);
      acc = -1;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_locked) begin
         if (in_valid[m_g] && (!m_ov || out_ready)) begin
            acc  = m_g;
            m_od = in_data[m_g*4 +: 4];
            m_ol = in_last[m_g];
            m_oc = m_g;
            m_ov = 1;
            if (in_last[m_g]) begin
               m_ptr    = m_g;
               m_locked = 0;
            end
         end else if (m_ov && out_ready) begin
            m_ov = 0;
         end
      end else begin
         if (m_ov && out_ready) m_ov = 0;
         if (mode == 1'b0) begin
            for (int k = 1; k <= 4; k++) begin
               if (!m_locked && in_valid[(m_ptr + k) % 4]) begin
                  m_g = (m_ptr + k) % 4;
                  m_locked = 1;
               end
            end
         end else if (int'(sel) < 4 && in_valid[sel]) begin
            m_g = int'(sel);
            m_locked = 1;
         end
      end
   endtask

   task automatic drive_producers();
      for (int c = 0; c < 4; c++) begin
         if (!pval[c] && ($urandom_range(99) < vprob)) begin
            if (rem[c] == 0) rem[c] = $urandom_range(1, 4);
            pdata[c] = 4'($urandom);
            pval[c]  = 1;
         end
         in_valid[c]       = pval[c];
         in_last[c]        = pval[c] && (rem[c] == 1);
         in_data[c*4 +: 4] = pdata[c];
      end
   endtask

   task automatic run_cycle();
      logic [3:0] exp_rdy;
      int         acc;
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("out_data", 32'(out_data), 32'(m_od));
      check("out_last", 32'(out_last), 32'(m_ol));
      check("out_chan", 32'(out_chan), 32'(m_oc));
      rst       = (rstp > 0) && ($urandom_range(rstp - 1) == 0);
      out_ready = ($urandom_range(99) < orp);
      if (pol == 0) begin
         mode = 1'b0;
      end else if (pol == 1) begin
         mode = 1'b1;
         sel  = 2'(fixsel);
      end else if ($urandom_range(4) == 0) begin
         mode = 1'($urandom);
         sel  = 2'($urandom);
      end
      drive_producers();
      #1;
      exp_rdy = (m_locked && (!m_ov || out_ready)) ? 4'(1 << m_g) : 4'b0;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      model_step(acc);
      if (acc >= 0) begin
         pval[acc] = 0;
         rem[acc]--;
      end
   endtask

   task automatic run_phase(input int n, input int vp, input int op, input int pl,
                            input int fs, input int rp);
      vprob = vp; orp = op; pol = pl; fixsel = fs; rstp = rp;
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_valid = '0; in_last = '0;
      mode = 1'b0; sel = '0; out_ready = 1'b1;
      d5_in_data = {4'hA, 16'h0}; d5_in_valid = '0; d5_in_last = '1;
      d5_mode = 1'b1; d5_sel = 3'd5; d5_out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_chan", 32'(out_chan), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      rst = 1'b0;

      // Single-beat packet from channel 2 only.
      rem[2] = 1; pval[2] = 1; pdata[2] = 4'b1110;
      run_phase(6, 0, 100, 0, 0, 0);

      run_phase(300, 100, 100, 0, 0, 0);   // all channels busy, round-robin
      run_phase(200, 100, 100, 1, 3, 0);   // fixed select of channel 3
      run_phase(400, 70, 100, 2, 0, 0);    // select changes while locked
      run_phase(400, 70, 40, 2, 0, 0);     // heavy backpressure
      run_phase(600, 60, 70, 2, 0, 40);    // random resets mid-packet
      run_phase(300, 100, 80, 0, 0, 0);

      // Out-of-range select on the five-channel instance never grants.
      @(negedge clk);
      d5_in_valid = '1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("d5_nogrant_valid", 32'(d5_out_valid), 32'd0);
         check("d5_nogrant_ready", 32'(d5_in_ready), 32'd0);
      end
      d5_sel = 3'd4;
      @(negedge clk);
      check("d5_sel4_ready", 32'(d5_in_ready), 32'b10000);
      @(negedge clk);
      check("d5_sel4_valid", 32'(d5_out_valid), 32'd1);
      check("d5_sel4_chan", 32'(d5_out_chan), 32'd4);
      check("d5_sel4_data", 32'(d5_out_data), 32'hA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
